// File: rtl/transmisor_uart_muestra.sv
// UART 8N1 transmitter for filter output samples: sends an ANCHO-bit sample as
// NB = ANCHO/8 back-to-back frames, most-significant byte first.
module transmisor_uart_muestra #(
  parameter int ANCHO   = 16,
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_tick,
  input  logic             listo,
  input  logic [ANCHO-1:0] yk,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done_tick,
  output logic             drop_tick
);

  localparam int NB = ANCHO / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [3:0]       s_q, s_d;
  logic [2:0]       n_q, n_d;
  logic [BW-1:0]    b_q, b_d;
  logic [ANCHO-1:0] sample_q, sample_d;
  logic [ANCHO-1:0] sample_shl;
  logic [DBIT-1:0]  shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic             accept;

  // The sample register shifts left one byte per frame, so the next byte to
  // send always sits in its top byte instead of being indexed by b.
  assign sample_shl = sample_q << 8;

  // done_q is high in the first IDLE cycle; a listo there is still dropped.
  assign accept = listo && (state_q == IDLE) && !done_q;

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    n_d      = n_q;
    b_d      = b_q;
    sample_d = sample_q;
    shreg_d  = shreg_q;
    done_d   = 1'b0;
    drop_d   = listo && !accept;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sample_d = yk;
          shreg_d  = DBIT'(yk[ANCHO-1 -: 8]);
          s_d      = '0;
          n_d      = '0;
          b_d      = '0;
          state_d  = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            s_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            s_d     = '0;
            shreg_d = shreg_q >> 1;
            if (n_q == 3'(DBIT - 1)) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == 4'(SB_TICK - 1)) begin
            s_d = '0;
            if (b_q != BW'(NB - 1)) begin
              b_d      = b_q + BW'(1);
              sample_d = sample_shl;
              shreg_d  = DBIT'(sample_shl[ANCHO-1 -: 8]);
              n_d      = '0;
              state_d  = START;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so tx changes on the same edge.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      s_q      <= '0;
      n_q      <= '0;
      b_q      <= '0;
      sample_q <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      n_q      <= n_d;
      b_q      <= b_d;
      sample_q <= sample_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;
  assign drop_tick    = drop_q;

endmodule

// File: tb/tb_transmisor_uart_muestra.sv
// Bench for transmisor_uart_muestra: 16-bit and 8-bit instances checked each
// cycle against a tick-count model of the serial waveform, plus directed cases.
module tb_transmisor_uart_muestra;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_tick = 1'b0;
  logic        listo16 = 1'b0;
  logic        listo8 = 1'b0;
  logic [15:0] yk16 = '0;
  logic [7:0]  yk8 = '0;
  logic        tx16, busy16, done16, drop16;
  logic        tx8, busy8, done8, drop8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  transmisor_uart_muestra #(.ANCHO(16), .DBIT(8), .SB_TICK(16)) dut16 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .listo(listo16), .yk(yk16),
    .tx(tx16), .tx_busy(busy16), .tx_done_tick(done16), .drop_tick(drop16)
  );

  transmisor_uart_muestra #(.ANCHO(8), .DBIT(8), .SB_TICK(16)) dut8 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .listo(listo8), .yk(yk8),
    .tx(tx8), .tx_busy(busy8), .tx_done_tick(done8), .drop_tick(drop8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level t ticks after acceptance: every bit lasts 16 ticks,
  // each byte is start + 8 data (LSB first) + stop, bytes MSB first.
  function automatic logic tx_bit(input logic [15:0] smp, input int t, input int nb);
    int idx, byt, pos;
    logic [7:0] v;
    idx = t / 16;
    byt = idx / 10;
    pos = idx % 10;
    v = 8'(smp >> (8 * (nb - 1 - byt)));
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return v[pos-1];
  endfunction

  // Tick generator: 0 = none, 1 = every 4 clk, 2 = random (1 in 3)
  int tick_mode = 0;
  int tick_div = 0;
  initial forever begin
    @(negedge clk);
    #1;
    case (tick_mode)
      1: begin
        tick_div = (tick_div + 1) % 4;
        s_tick = (tick_div == 0);
      end
      2: s_tick = ($urandom_range(0, 2) == 0);
      default: s_tick = 1'b0;
    endcase
  end

  // Behavioural model: index 0 = 16-bit instance, 1 = 8-bit instance
  logic        m_act[2];
  int          m_t[2];
  logic [15:0] m_smp[2];
  logic        m_done[2];
  logic        m_drop[2];
  int          tick_cnt = 0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 1'b0; m_t[k] = 0; m_done[k] = 1'b0; m_drop[k] = 1'b0; m_smp[k] = '0;
      end
    end else begin
      if (s_tick) tick_cnt++;
      for (int k = 0; k < 2; k++) begin
        logic lst, prev_done;
        int nb;
        lst = (k == 0) ? listo16 : listo8;
        nb = (k == 0) ? 2 : 1;
        prev_done = m_done[k];
        m_done[k] = 1'b0;
        m_drop[k] = 1'b0;
        if (m_act[k]) begin
          if (lst) m_drop[k] = 1'b1;
          if (s_tick) begin
            m_t[k]++;
            if (m_t[k] == 160 * nb) begin
              m_act[k] = 1'b0;
              m_done[k] = 1'b1;
            end
          end
        end else if (lst) begin
          if (prev_done) m_drop[k] = 1'b1;
          else begin
            m_act[k] = 1'b1;
            m_t[k] = 0;
            m_smp[k] = (k == 0) ? yk16 : {8'h00, yk8};
          end
        end
      end
    end
  end

  // Per-cycle compare, plus bookkeeping of observed pulses for directed checks
  int drops16 = 0;
  int done_at16 = 0;
  int done_at8 = 0;
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic etx;
      etx = m_act[k] ? tx_bit(m_smp[k], m_t[k], (k == 0) ? 2 : 1) : 1'b1;
      check((k == 0) ? "tx16" : "tx8", (k == 0) ? tx16 : tx8, etx);
      check((k == 0) ? "busy16" : "busy8", (k == 0) ? busy16 : busy8, m_act[k]);
      check((k == 0) ? "done16" : "done8", (k == 0) ? done16 : done8, m_done[k]);
      check((k == 0) ? "drop16" : "drop8", (k == 0) ? drop16 : drop8, m_drop[k]);
    end
    if (drop16) drops16++;
    if (done16) done_at16 = tick_cnt;
    if (done8) done_at8 = tick_cnt;
  end

  int base = 0;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rel(input int target, input string name);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (tick_cnt - base >= target) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) check({name, "_timeout"}, ok, 1'b1);
  endtask

  task automatic wait_done(input int k);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      step();
      if ((k == 0) ? done16 : done8) begin ok = 1'b1; break; end
    end
    if (!ok) check("wait_done_timeout", ok, 1'b1);
  endtask

  task automatic wait_idle(input int k);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (!m_act[k] && !m_done[k]) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) check("wait_idle_timeout", ok, 1'b1);
  endtask

  task automatic send16(input logic [15:0] v);
    wait_idle(0);
    listo16 = 1'b1; yk16 = v;
    step();
    listo16 = 1'b0; yk16 = 16'($urandom);
    base = tick_cnt;
  endtask

  task automatic send8(input logic [7:0] v);
    wait_idle(1);
    listo8 = 1'b1; yk8 = v;
    step();
    listo8 = 1'b0; yk8 = 8'($urandom);
    base = tick_cnt;
  endtask

  logic exp_a[20] = '{0,1,0,1,0,0,1,0,1,1, 0,0,0,1,1,1,1,0,0,1};

  initial begin
    int d0;
    repeat (3) step();
    check("reset_tx", tx16, 1'b1);
    check("reset_busy", busy16, 1'b0);
    reset = 1'b1;
    step();

    // 0xA53C at one tick per 4 clk, with a second listo 10 ticks in
    tick_mode = 1;
    send16(16'hA53C);
    check("accept_tx_low", tx16, 1'b0);
    for (int i = 0; i < 20; i++) begin
      wait_rel(16 * i + 8, "bitA");
      check($sformatf("a53c_bit%0d", i), tx16, exp_a[i]);
      if (i == 0) begin
        wait_rel(10, "drop_at10");
        d0 = drops16;
        listo16 = 1'b1; yk16 = 16'h1234;
        step();
        listo16 = 1'b0;
      end
    end
    check("drop_once", drops16 - d0, 1);
    wait_done(0);
    check("done_after_320", done_at16 - base, 320);

    // listo during the done pulse is dropped, one cycle later it is taken
    d0 = drops16;
    listo16 = 1'b1; yk16 = 16'h5AC3;
    step();
    step();
    listo16 = 1'b0;
    base = tick_cnt;
    check("done_cycle_drop", drops16 - d0, 1);
    check("next_cycle_accept_tx", tx16, 1'b0);
    check("next_cycle_accept_busy", busy16, 1'b1);
    tick_mode = 2;
    wait_done(0);

    // reset in a data bit of the second byte, then 0x0001
    tick_mode = 1;
    send16(16'($urandom));
    wait_rel(160 + 16 + 40, "to_byte2");
    reset = 1'b0;
    #1;
    check("midframe_reset_tx", tx16, 1'b1);
    check("midframe_reset_busy", busy16, 1'b0);
    repeat (3) step();
    reset = 1'b1;
    step();
    send16(16'h0001);
    wait_rel(16 * 1 + 8, "b0001_lo");
    check("b0001_first_data", tx16, 1'b0);
    wait_rel(16 * 11 + 8, "b0001_hi");
    check("b0001_second_lsb", tx16, 1'b1);
    wait_done(0);

    // 8-bit instance, 0xFF
    send8(8'hFF);
    for (int i = 0; i < 10; i++) begin
      wait_rel(16 * i + 8, "bit8");
      check($sformatf("ff_bit%0d", i), tx8, (i == 0) ? 1'b0 : 1'b1);
    end
    wait_done(1);
    check("done8_after_160", done_at8 - base, 160);

    // tick stall in START
    send16(16'($urandom));
    wait_rel(5, "stall");
    tick_mode = 0;
    repeat (1000) step();
    check("stall_tx", tx16, 1'b0);
    check("stall_busy", busy16, 1'b1);
    tick_mode = 1;
    wait_done(0);

    // randomized traffic with occasional reset
    tick_mode = 2;
    for (int c = 0; c < 15000; c++) begin
      step();
      listo16 = ($urandom_range(0, 199) == 0);
      yk16 = 16'($urandom);
      listo8 = ($urandom_range(0, 149) == 0);
      yk8 = 8'($urandom);
      reset = ($urandom_range(0, 2999) != 0);
    end
    step();
    listo16 = 1'b0;
    listo8 = 1'b0;
    reset = 1'b1;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
